// File: rtl/token_rx_if.sv
// Line-side bit stream in, assembled token word and status pulses out.
interface token_rx_if #(
  parameter int unsigned TOKEN_BITS = 24
);
  logic                  rx_valid;
  logic                  rx_bit;
  logic                  rx_se0;
  logic [TOKEN_BITS-1:0] data;
  logic                  token_valid;
  logic                  rx_err;
  logic [1:0]            err_type;

  modport master (
    output rx_valid, rx_bit, rx_se0,
    input  data, token_valid, rx_err, err_type
  );

  modport slave (
    input  rx_valid, rx_bit, rx_se0,
    output data, token_valid, rx_err, err_type
  );
endinterface

// File: rtl/token_rx.sv
// USB token receive stage: SYNC hunt, bit unstuffing, 24-bit token assembly
// and EOP framing check. PID and CRC5 are passed through uninterpreted.
module token_rx #(
  parameter logic [7:0]  SYNC_PATTERN = 8'b0000_0001,
  parameter int unsigned TOKEN_BITS   = 24
) (
  input logic       clk,
  input logic       reset,
  token_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(TOKEN_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(TOKEN_BITS - 1);

  typedef enum logic [1:0] {HUNT, DATA, EOP1, EOP2} state_t;

  typedef enum logic [3:0] {
    EV_IDLE, EV_HUNT, EV_SYNC, EV_SHIFT, EV_UNSTUFF, EV_EOP, EV_EOP_WAIT,
    EV_TOKEN, EV_ERR_STUFF, EV_ERR_LEN, EV_ERR_EOP
  } event_t;

  state_t                state_q, state_d;
  event_t                ev;
  logic [7:0]            win_q, win_d;
  logic [2:0]            ones_q, ones_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TOKEN_BITS-1:0] sh_q, sh_d;
  logic [TOKEN_BITS-1:0] data_q, data_d;
  logic                  extra_q, extra_d;
  logic                  tv_q, tv_d;
  logic                  err_q, err_d;
  logic [1:0]            etype_q, etype_d;

  logic [7:0] win_next;
  logic       stuff_due;

  assign win_next  = {win_q[6:0], bus.rx_bit};
  assign stuff_due = (ones_q == 3'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      win_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      extra_q <= 1'b0;
      tv_q    <= 1'b0;
      err_q   <= 1'b0;
      etype_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      extra_q <= extra_d;
      tv_q    <= tv_d;
      err_q   <= err_d;
      etype_q <= etype_d;
    end
  end

  // Next state plus a classification of what this strobe means; the
  // datapath/output process acts on the classification only.
  always_comb begin
    state_d = state_q;
    ev      = EV_IDLE;
    if (bus.rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (!bus.rx_se0 && win_next == SYNC_PATTERN) begin
            ev      = EV_SYNC;
            state_d = DATA;
          end else begin
            ev = EV_HUNT;
          end
        end
        DATA: begin
          if (bus.rx_se0) begin
            ev      = EV_ERR_LEN;
            state_d = HUNT;
          end else if (stuff_due) begin
            if (bus.rx_bit) begin
              ev      = EV_ERR_STUFF;
              state_d = HUNT;
            end else begin
              ev = EV_UNSTUFF;
            end
          end else begin
            ev = EV_SHIFT;
            if (cnt_q == LAST_BIT) state_d = EOP1;
          end
        end
        EOP1: begin
          if (bus.rx_se0) begin
            ev      = EV_EOP;
            state_d = EOP2;
          end else if (stuff_due && !bus.rx_bit) begin
            ev = EV_UNSTUFF;
          end else if (stuff_due) begin
            ev      = EV_ERR_STUFF;
            state_d = HUNT;
          end else begin
            ev      = EV_ERR_LEN;
            state_d = HUNT;
          end
        end
        EOP2: begin
          if (bus.rx_se0 && extra_q) begin
            ev      = EV_ERR_EOP;
            state_d = HUNT;
          end else if (bus.rx_se0) begin
            ev = EV_EOP_WAIT;
          end else begin
            ev      = EV_TOKEN;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    win_d   = win_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    extra_d = extra_q;
    tv_d    = 1'b0;
    err_d   = 1'b0;
    etype_d = '0;
    unique case (ev)
      EV_HUNT: win_d = bus.rx_se0 ? '0 : win_next;
      EV_SYNC: begin
        win_d   = '0;
        cnt_d   = '0;
        ones_d  = 3'd1;
        extra_d = 1'b0;
      end
      EV_SHIFT: begin
        sh_d   = {sh_q[TOKEN_BITS-2:0], bus.rx_bit};
        cnt_d  = cnt_q + 1'b1;
        ones_d = bus.rx_bit ? ones_q + 3'd1 : 3'd0;
      end
      EV_UNSTUFF:  ones_d  = '0;
      EV_EOP:      extra_d = 1'b0;
      EV_EOP_WAIT: extra_d = 1'b1;
      EV_TOKEN: begin
        data_d = sh_q;
        tv_d   = 1'b1;
      end
      EV_ERR_STUFF: begin
        err_d   = 1'b1;
        etype_d = 2'b01;
      end
      EV_ERR_LEN: begin
        err_d   = 1'b1;
        etype_d = 2'b10;
      end
      EV_ERR_EOP: begin
        err_d   = 1'b1;
        etype_d = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.token_valid = tv_q;
  assign bus.rx_err      = err_q;
  assign bus.err_type    = etype_q;

endmodule

// File: doc/token_rx.md
# token_rx

Serial-to-parallel receive stage for USB token packets; sits directly upstream of the token decoder and feeds it a 24-bit token word. Takes the NRZI-decoded line bit stream with a per-bit strobe, hunts for SYNC, removes bit stuffing, assembles PID/ADDR/ENDP/CRC5 into `data[23:0]`, validates the EOP framing, and emits a one-cycle `token_valid` or `rx_err` pulse. It does not interpret the PID and does not check the CRC; both belong to the decoder.

## Interface
- `SYNC_PATTERN`, 8'b0000_0001, decoded SYNC field, last received bit in LSB.
- `TOKEN_BITS`, 24, unstuffed bits per token (PID 8 + ADDR 7 + ENDP 4 + CRC5 5).

- `clk`  input  1  single clock; all logic rises on `posedge clk`.
- `reset`  input  1  synchronous, active-high.
- `rx_valid`  input  1  strobe; one line bit is present when high; may be low for any number of cycles between bits.
- `rx_bit`  input  1  NRZI-decoded bit; sampled only when `rx_valid`=1.
- `rx_se0`  input  1  line is SE0 for this bit time; sampled only when `rx_valid`=1; overrides `rx_bit`.
- `data`  output  24  assembled token; the first received bit is in `data[23]`; held until the next successful token.
- `token_valid`  output  1  one-cycle pulse; `data` is valid the same cycle.
- `rx_err`  output  1  one-cycle pulse on an aborted packet.
- `err_type`  output  2  valid with `rx_err`: 01 stuff error, 10 length error (early or late EOP), 11 malformed EOP; 00 otherwise.

## Operation
- Only cycles with `rx_valid`=1 advance the logic; all other cycles hold state.
- States are HUNT, DATA, EOP1, EOP2.
- HUNT: an 8-bit window shifts in `rx_bit`. SE0 bits clear the window. When the window equals `SYNC_PATTERN`, the block clears the bit counter, sets `ones_cnt`=1 (the final SYNC bit counts toward stuffing), and goes to DATA.
- Stuffing, in DATA and EOP1:
  - A non-SE0 bit with `rx_bit`=1 increments `ones_cnt`.
  - A 0 clears `ones_cnt`.
  - When `ones_cnt`=6, the next bit is a stuff bit. If it is 0, discard it and clear the counter. If it is 1, pulse `rx_err` with `err_type`=01 and go to HUNT.
- DATA: each unstuffed bit shifts into the internal register `{sh[22:0], rx_bit}` and increments `bit_cnt`.
  - On `bit_cnt` reaching `TOKEN_BITS`, go to EOP1.
  - An SE0 before 24 bits gives `rx_err` with `err_type`=10, then HUNT.
- EOP1: SE0 goes to EOP2. A stuff bit is handled as above. Any other non-SE0 bit (a 25th data bit) gives error 10, then HUNT.
- EOP2: SE0 waits here (exactly one more SE0 is accepted). A non-SE0 bit, i.e. the J, loads `data`<=`sh`, pulses `token_valid`, and returns to HUNT.
- A third consecutive SE0 in EOP2 gives error 11, then HUNT.
- `data` changes only on a successful token. On an error it keeps its previous value.
- `token_valid` and `rx_err` are never high in the same cycle.
- `reset` (at any time, including mid-packet) drives state to HUNT and clears the window, counters and shift register.

## Timing
- Reset values: `data`=0, `token_valid`=0, `rx_err`=0, `err_type`=0.
- All outputs are registered.
- `token_valid` is high in the clk cycle after the edge that samples the J strobe. Latency from the J strobe is 1 clk.
- `rx_err`/`err_type` are high in the cycle after the offending strobe. `err_type` returns to 00 the following cycle.
- A new SYNC may start on the strobe immediately after a completion or error. No dead bits are required.
- Throughput: one bit per `rx_valid`, including back-to-back strobes every clk.

## Test plan
- Basic token:
  - Stimulus: SYNC 00000001, then bits 100101100000000000001101, then SE0, SE0, J. Strobes every clk.
  - Required: `data`=24'h96000D and a single `token_valid` pulse 1 clk after the J strobe; `rx_err` stays 0.
- Unstuffing:
  - Stimulus: SYNC, 0, 111111, stuffed 0, then 0 plus 16 zeros, then EOP.
  - Required: `data`=24'h7E0000, `token_valid` pulses once.
- Stuff error:
  - Stimulus: same as unstuffing, but the stuffed bit is sent as 1.
  - Required: `rx_err`=1 with `err_type`=01 for one clk; no `token_valid`; `data` unchanged. A following valid token decodes correctly.
- Length errors:
  - Stimulus A: SE0 after 10 data bits. Stimulus B: a 25th data bit instead of SE0.
  - Required: each gives `rx_err` with `err_type`=10 and no `token_valid`.
- Malformed EOP:
  - Stimulus: three consecutive SE0s after 24 bits.
  - Required: `err_type`=11.
- Gaps and reset:
  - Stimulus: basic token with `rx_valid` low for 0–5 random cycles between bits. Separately, `reset` pulsed after 12 data bits.
  - Required: with gaps, the result is identical to the basic token. With reset, all outputs read 0 the next cycle, and a full token sent afterwards yields 24'h96000D.
